// File: rtl/instr_loader.sv
// instr_loader: fills instruction memory from a length-prefixed little-endian
// byte stream and holds the CPU in reset until the whole program is written.
// Stream format: len[7:0], len[15:8], then 4*len bytes (one word per 4 bytes).
// Handshake: a byte moves on a rising edge where byte_valid && byte_ready;
// byte_ready is a registered decode of the state, and byte_valid is ignored
// whenever byte_ready is low.
module instr_loader #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_DEPTH     = 256,
  parameter int BASE_ADDR     = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     byte_valid,
  input  logic [7:0]               byte_in,
  output logic                     byte_ready,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic                     cpu_rst,
  output logic                     done,
  output logic                     error
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  localparam logic [15:0]              LEN_MAX = 16'(MEM_DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] BASE    = ADDRESS_WIDTH'(BASE_ADDR);

  // state is the observable FSM state for checkers and debug
  state_t      state;
  state_t      state_next;

  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [15:0] len_full;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [23:0] word_buf;
  logic        xfer;
  logic        last_byte;
  logic        last_word;
  logic        start_take;

  logic        byte_ready_d;
  logic        mem_we_d;
  logic        cpu_rst_d;
  logic        done_d;
  logic        error_d;

  assign xfer       = byte_valid && byte_ready;
  assign len_full   = {byte_in, len_lo};
  assign last_byte  = (state == S_DATA) && xfer && (byte_idx == 2'd3);
  assign last_word  = (word_idx == (len - 16'd1));
  assign start_take = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_LEN_LO;
      S_LEN_LO: if (xfer) state_next = S_LEN_HI;
      S_LEN_HI: begin
        if (xfer) begin
          if (len_full == 16'd0)       state_next = S_DONE;
          else if (len_full > LEN_MAX) state_next = S_ERR;
          else                         state_next = S_DATA;
        end
      end
      S_DATA:   if (last_byte && last_word) state_next = S_DONE;
      S_DONE:   if (start) state_next = S_LEN_LO;
      S_ERR:    if (start) state_next = S_LEN_LO;
      default:  state_next = S_IDLE;
    endcase
  end

  // Output decode; cpu_rst follows the current state so it drops one cycle after done
  always_comb begin
    byte_ready_d = (state_next == S_LEN_LO) || (state_next == S_LEN_HI) ||
                   (state_next == S_DATA);
    mem_we_d     = last_byte;
    done_d       = (state_next == S_DONE);
    error_d      = (state_next == S_ERR);
    cpu_rst_d    = (state != S_DONE);
  end

  // Registered control outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      cpu_rst    <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      byte_ready <= byte_ready_d;
      mem_we     <= mem_we_d;
      cpu_rst    <= cpu_rst_d;
      done       <= done_d;
      error      <= error_d;
    end
  end

  // Length capture, word assembly and write address/data
  always_ff @(posedge clk) begin
    if (rst) begin
      len_lo    <= 8'd0;
      len       <= 16'd0;
      word_idx  <= 16'd0;
      byte_idx  <= 2'd0;
      word_buf  <= 24'd0;
      mem_addr  <= BASE;
      mem_wdata <= '0;
    end else if (start_take) begin
      len       <= 16'd0;
      word_idx  <= 16'd0;
      byte_idx  <= 2'd0;
    end else begin
      if ((state == S_LEN_LO) && xfer) len_lo <= byte_in;
      if ((state == S_LEN_HI) && xfer) len    <= len_full;
      if ((state == S_DATA) && xfer) begin
        byte_idx <= byte_idx + 2'd1;
        case (byte_idx)
          2'd0:    word_buf[7:0]   <= byte_in;
          2'd1:    word_buf[15:8]  <= byte_in;
          2'd2:    word_buf[23:16] <= byte_in;
          default: begin
            mem_wdata <= DATA_WIDTH'({byte_in, word_buf});
            mem_addr  <= BASE + ADDRESS_WIDTH'({word_idx, 2'b00});
            word_idx  <= word_idx + 16'd1;
          end
        endcase
      end
    end
  end

endmodule
